// File: rtl/aer_event_encoder.sv
// Address-event front end: queues serial events with their arrival timestamp and
// replays them in order as one-cycle one-hot pulses, at least p_gap cycles apart.
module aer_event_encoder #(
  parameter int p_width = 9,
  parameter int p_depth = 4,
  parameter int p_gap   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [2:0]               i_addr,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_flush,
  output logic [8:1]               o_event,
  output logic [p_width-1:0]       o_ts,
  output logic [$clog2(p_depth):0] o_level,
  output logic                     o_busy,
  output logic [1:0]               o_state
);
  localparam int AW = $clog2(p_depth);
  localparam int LW = AW + 1;
  localparam int EW = 3 + p_width;
  localparam int CW = $clog2(p_gap + 1);
  localparam logic [CW-1:0] GAP_INIT = (p_gap > 1) ? CW'(p_gap - 2) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [p_width-1:0] ts_q;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      count_q, count_d;
  logic [8:1]         event_q, event_d;
  logic [p_width-1:0] ts_out_q, ts_out_d;
  logic [EW-1:0]      mem_q [p_depth];

  logic               full, empty, push, pop;
  logic [EW-1:0]      head;
  logic [2:0]         head_addr;
  logic [p_width-1:0] head_ts;

  assign full      = (count_q == LW'(p_depth));
  assign empty     = (count_q == '0);
  assign head      = mem_q[rd_ptr_q];
  assign head_addr = head[EW-1:p_width];
  assign head_ts   = head[p_width-1:0];

  // Handshake: a transfer happens on a clock edge where i_valid & o_ready are both
  // high; o_ready never depends on i_valid and a same-cycle pop does not free a slot.
  assign o_ready = !full && !i_flush && !i_rst;
  assign push    = i_valid && o_ready;

  assign o_event = event_q;
  assign o_ts    = ts_out_q;
  assign o_level = count_q;
  assign o_busy  = !empty || (state_q != S_IDLE);
  assign o_state = state_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    event_d  = '0;
    ts_out_d = ts_out_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (p_gap == 1) begin
          if (!empty) pop = 1'b1;
          else        state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
          cnt_d   = GAP_INIT;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_EMIT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      event_d  = 8'b1 << head_addr;
      ts_out_d = head_ts;
    end
    // Flush wins over everything: no pop, back to IDLE, the shown pulse simply ends.
    if (i_flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      pop      = 1'b0;
      event_d  = '0;
      ts_out_d = ts_out_q;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + LW'(1);
      else if (!push && pop) count_d = count_q - LW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ts_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      event_q  <= '0;
      ts_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ts_q     <= ts_q + p_width'(1);
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      event_q  <= event_d;
      ts_out_q <= ts_out_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are meaningful.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_addr, ts_q};
  end

endmodule
